// File: rtl/pix_stream_unpack.sv
// rtl/pix_stream_unpack.sv - ping-pong word prefetch and per-pixel serialiser for the display path
module pix_stream_unpack #(
    parameter int               PIX_W        = 24,
    parameter int               PIX_PER_WORD = 10,
    parameter int               WORD_W       = PIX_W * PIX_PER_WORD,
    parameter bit               MSB_FIRST    = 1'b1,
    parameter bit               RESYNC       = 1'b1,
    parameter logic [PIX_W-1:0] BLANK_RGB    = PIX_W'(24'h00_fc_0d),
    parameter logic [PIX_W-1:0] UFLOW_RGB    = PIX_W'(24'hff_00_ff),
    parameter int               CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic [PIX_W-1:0]  pix_out,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic              uflow_sticky,
    output logic [CNT_W-1:0]  uflow_cnt,
    input  logic              uflow_clr
);

    localparam int               IDX_W    = $clog2(PIX_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] slot_data [2];
    logic [1:0]        slot_vld;
    logic              wp;
    logic              rp;
    logic [IDX_W-1:0]  pix_idx;
    logic [1:0]        occ;
    logic              rd_d;

    logic [WORD_W-1:0] cur_word;
    logic [PIX_W-1:0]  pix_arr [PIX_PER_WORD];

    logic              consume;
    logic              uflow_evt;
    logic              vs_rise;
    logic              drop;
    logic              issue;
    logic [1:0]        occ_dec;
    logic [1:0]        occ_left;
    logic [1:0]        occ_n;
    logic [1:0]        vld_n;
    logic              rp_n;
    logic [IDX_W-1:0]  idx_n;

    assign cur_word = slot_data[rp];

    for (genvar g = 0; g < PIX_PER_WORD; g++) begin : g_pix
        if (MSB_FIRST) begin : g_msb
            assign pix_arr[g] = cur_word[WORD_W-1-g*PIX_W -: PIX_W];
        end else begin : g_lsb
            assign pix_arr[g] = cur_word[g*PIX_W +: PIX_W];
        end
    end

    // vs_out is vs_in delayed by one cycle, so it doubles as the edge-detect history
    always_comb begin
        consume   = de_in & slot_vld[rp];
        uflow_evt = de_in & ~slot_vld[rp];
        vs_rise   = RESYNC & vs_in & ~vs_out;
        vld_n     = slot_vld;
        rp_n      = rp;
        idx_n     = pix_idx;
        occ_dec   = 2'd0;

        if (consume) begin
            if (pix_idx == IDX_LAST) begin
                vld_n[rp] = 1'b0;
                rp_n      = ~rp;
                idx_n     = '0;
                occ_dec   = 2'd1;
            end else begin
                idx_n = pix_idx + IDX_W'(1);
            end
        end

        // A partly consumed word is abandoned on frame start; whole words survive
        drop = vs_rise & (idx_n != '0);
        if (drop) begin
            vld_n[rp_n] = 1'b0;
            rp_n        = ~rp_n;
            idx_n       = '0;
            occ_dec     = occ_dec + 2'd1;
        end

        occ_left = occ - occ_dec;
        issue    = ~fifo_empty & ~fifo_rd_en & (occ_left < 2'd2);
        occ_n    = occ_left + {1'b0, issue};

        // The landing slot is never the one just freed, so this cannot clobber it
        if (rd_d) begin
            vld_n[wp] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_rd_en   <= 1'b0;
            rd_d         <= 1'b0;
            slot_vld     <= 2'b00;
            wp           <= 1'b0;
            rp           <= 1'b0;
            pix_idx      <= '0;
            occ          <= 2'd0;
            pix_out      <= '0;
            de_out       <= 1'b0;
            hs_out       <= 1'b0;
            vs_out       <= 1'b0;
            uflow_sticky <= 1'b0;
            uflow_cnt    <= '0;
        end else begin
            fifo_rd_en <= issue;
            rd_d       <= fifo_rd_en;
            slot_vld   <= vld_n;
            rp         <= rp_n;
            pix_idx    <= idx_n;
            occ        <= occ_n;
            if (rd_d) begin
                wp <= ~wp;
            end

            de_out <= de_in;
            hs_out <= hs_in;
            vs_out <= vs_in;
            if (!de_in) begin
                pix_out <= BLANK_RGB;
            end else if (consume) begin
                pix_out <= pix_arr[pix_idx];
            end else begin
                pix_out <= UFLOW_RGB;
            end

            if (uflow_clr) begin
                uflow_sticky <= uflow_evt;
                uflow_cnt    <= uflow_evt ? CNT_W'(1) : '0;
            end else if (uflow_evt) begin
                uflow_sticky <= 1'b1;
                if (!(&uflow_cnt)) begin
                    uflow_cnt <= uflow_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_d) begin
            slot_data[wp] <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_pix_stream_unpack.sv
// tb/tb_pix_stream_unpack.sv - directed checks of pix_stream_unpack in LSB/resync and MSB/no-resync builds
module tb_pix_stream_unpack;

    localparam logic [7:0] BLANK = 8'h0d;
    localparam logic [7:0] UFLOW = 8'hee;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int b2b   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // instance A: LSB-first, resync enabled, 16-bit counter
    logic        rstn_a = 1'b0, de_a = 1'b0, hs_a = 1'b0, vs_a = 1'b0, clr_a = 1'b0;
    logic        rd_en_a, empty_a, deo_a, hso_a, vso_a, stk_a;
    logic [31:0] rdata_a = '0;
    logic [7:0]  pix_a;
    logic [15:0] cnt_a;
    logic [31:0] mem_a [16];
    logic [3:0]  wr_a = '0, rd_a = '0;

    assign empty_a = (wr_a == rd_a);
    always @(posedge clk) begin
        if (rd_en_a) begin
            rdata_a <= mem_a[rd_a];
            rd_a    <= rd_a + 4'd1;
        end
    end

    pix_stream_unpack #(
        .PIX_W(8), .PIX_PER_WORD(4), .MSB_FIRST(1'b0), .RESYNC(1'b1),
        .BLANK_RGB(BLANK), .UFLOW_RGB(UFLOW), .CNT_W(16)
    ) u_a (
        .clk(clk), .rstn(rstn_a), .de_in(de_a), .hs_in(hs_a), .vs_in(vs_a),
        .fifo_rd_en(rd_en_a), .fifo_rdata(rdata_a), .fifo_empty(empty_a),
        .pix_out(pix_a), .de_out(deo_a), .hs_out(hso_a), .vs_out(vso_a),
        .uflow_sticky(stk_a), .uflow_cnt(cnt_a), .uflow_clr(clr_a)
    );

    // instance B: MSB-first, resync disabled, 2-bit counter
    logic        rstn_b = 1'b0, de_b = 1'b0, hs_b = 1'b0, vs_b = 1'b0, clr_b = 1'b0;
    logic        rd_en_b, empty_b, deo_b, hso_b, vso_b, stk_b;
    logic [31:0] rdata_b = '0;
    logic [7:0]  pix_b;
    logic [1:0]  cnt_b;
    logic [31:0] mem_b [16];
    logic [3:0]  wr_b = '0, rd_b = '0;

    assign empty_b = (wr_b == rd_b);
    always @(posedge clk) begin
        if (rd_en_b) begin
            rdata_b <= mem_b[rd_b];
            rd_b    <= rd_b + 4'd1;
        end
    end

    pix_stream_unpack #(
        .PIX_W(8), .PIX_PER_WORD(4), .MSB_FIRST(1'b1), .RESYNC(1'b0),
        .BLANK_RGB(BLANK), .UFLOW_RGB(UFLOW), .CNT_W(2)
    ) u_b (
        .clk(clk), .rstn(rstn_b), .de_in(de_b), .hs_in(hs_b), .vs_in(vs_b),
        .fifo_rd_en(rd_en_b), .fifo_rdata(rdata_b), .fifo_empty(empty_b),
        .pix_out(pix_b), .de_out(deo_b), .hs_out(hso_b), .vs_out(vso_b),
        .uflow_sticky(stk_b), .uflow_cnt(cnt_b), .uflow_clr(clr_b)
    );

    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if ((rd_en_a && prev_a) || (rd_en_b && prev_b)) b2b <= b2b + 1;
        prev_a <= rd_en_a;
        prev_b <= rd_en_b;
    end

    logic [3:0]  hpat = 4'b1101;
    logic [3:0]  vpat = 4'b0110;
    logic [7:0]  exp_b [12] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h03, 8'h02,
                                8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};

    initial begin
        // reset held with data available and de high
        mem_a[0] = 32'h03020100;
        mem_a[1] = 32'h07060504;
        wr_a = 4'd2;
        de_a = 1'b1; hs_a = 1'b1; vs_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_en", rd_en_a, 0);
            chk("rst_pix", pix_a, 0);
            chk("rst_de", deo_a, 0);
            chk("rst_hs", hso_a, 0);
            chk("rst_vs", vso_a, 0);
        end
        chk("rst_cnt", cnt_a, 0);
        chk("rst_sticky", stk_a, 0);

        rstn_a = 1'b1; de_a = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
        @(negedge clk); chk("start_edge1_rd", rd_en_a, 1);
        @(negedge clk); chk("start_edge2_rd", rd_en_a, 0);
        @(negedge clk); chk("start_edge3_rd", rd_en_a, 1);
        repeat (3) @(negedge clk);

        // LSB-first stream across two words
        de_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_pix", pix_a, i);
            chk("lsb_de", deo_a, 1);
        end
        de_a = 1'b0;
        chk("lsb_no_uflow", cnt_a, 0);

        // blanking with toggling sync
        for (int i = 0; i < 4; i++) begin
            hs_a = hpat[i]; vs_a = vpat[i];
            @(negedge clk);
            chk("blank_pix", pix_a, BLANK);
            chk("blank_de", deo_a, 0);
            chk("blank_hs", hso_a, hpat[i]);
            chk("blank_vs", vso_a, vpat[i]);
        end
        hs_a = 1'b0; vs_a = 1'b0;
        @(negedge clk);

        // underflow with empty FIFO, then clear, then clear colliding with an event
        de_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("uflow_pix", pix_a, UFLOW);
        end
        de_a = 1'b0;
        chk("uflow_cnt3", cnt_a, 3);
        chk("uflow_sticky", stk_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("clr_cnt", cnt_a, 0);
        chk("clr_sticky", stk_a, 0);
        clr_a = 1'b1; de_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0; de_a = 1'b0;
        chk("clr_evt_cnt", cnt_a, 1);
        chk("clr_evt_sticky", stk_a, 1);

        // resync drops the half-consumed word
        mem_a[2] = 32'h03020100;
        mem_a[3] = 32'h07060504;
        wr_a = 4'd4;
        repeat (7) @(negedge clk);
        de_a = 1'b1;
        @(negedge clk); chk("rs_pix0", pix_a, 8'h00);
        @(negedge clk); chk("rs_pix1", pix_a, 8'h01);
        de_a = 1'b0; vs_a = 1'b1;
        @(negedge clk);
        vs_a = 1'b0; de_a = 1'b1;
        @(negedge clk); chk("rs_after", pix_a, 8'h04);
        @(negedge clk); chk("rs_after2", pix_a, 8'h05);
        de_a = 1'b0;

        // instance B: MSB-first order, vsync ignored, saturating 2-bit counter
        mem_b[0] = 32'hA0B0C0D0;
        mem_b[1] = 32'h03020100;
        mem_b[2] = 32'h07060504;
        wr_b = 4'd3;
        rstn_b = 1'b1;
        repeat (7) @(negedge clk);
        de_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("msb_pix", pix_b, exp_b[i]);
        end
        de_b = 1'b0; vs_b = 1'b1;
        @(negedge clk);
        vs_b = 1'b0; de_b = 1'b1;
        for (int i = 6; i < 12; i++) begin
            @(negedge clk);
            chk("noresync_pix", pix_b, exp_b[i]);
        end
        chk("b_no_uflow", cnt_b, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_uflow_pix", pix_b, UFLOW);
            if (i == 2) chk("b_cnt3", cnt_b, 3);
        end
        chk("b_cnt_sat", cnt_b, 3);
        chk("b_sticky", stk_b, 1);

        // asynchronous reset mid-frame
        @(negedge clk);
        rstn_b = 1'b0;
        #1;
        chk("arst_pix", pix_b, 0);
        chk("arst_de", deo_b, 0);
        chk("arst_cnt", cnt_b, 0);
        chk("arst_sticky", stk_b, 0);
        chk("arst_rd_en", rd_en_b, 0);
        de_b = 1'b0;
        @(negedge clk);

        chk("no_back_to_back_rd", b2b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pix_stream_unpack.md
# pix_stream_unpack

Single-clock, parametrised pixel unpacker that sits between the pixel-buffer FIFO read port and the HDMI encoder. It prefetches packed multi-pixel words from a FIFO into a two-slot ping-pong buffer. During active video it serialises them one pixel per clock, aligned to the incoming video timing. It adds what the previous display path lacked: generic pixel width, pixels per word and packing order, underflow detection and counting, and per-frame realignment on VSYNC.

## Interface
- PIX_W, 24: bits per pixel.
- PIX_PER_WORD, 10: pixels packed per FIFO word; must be ≥2.
- WORD_W, PIX_W*PIX_PER_WORD: derived FIFO word width; not overridden.
- MSB_FIRST, 1: 1 = pixel 0 at word MSBs; 0 = pixel 0 at word LSBs.
- RESYNC, 1: 1 = drop a partially consumed word on a VSYNC rising edge.
- BLANK_RGB, 24'h00_fc_0d: value on pix_out while de_in is low (PIX_W bits).
- UFLOW_RGB, 24'hff_00_ff: value on pix_out during an underflow pixel.
- CNT_W, 16: width of the underflow counter.

Ports:
- clk  in  1  sole clock (pixel clock).
- rstn  in  1  reset; **one clock; reset is asynchronous and active-low**.
- de_in, hs_in, vs_in  in  1 each  timing from the H/V counter.
- fifo_rd_en  out  1  registered read strobe to the FIFO.
- fifo_rdata  in  WORD_W  FIFO data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- pix_out  out  PIX_W  pixel data.
- de_out, hs_out, vs_out  out  1 each  timing delayed to match pix_out.
- uflow_sticky  out  1  set on any underflow pixel.
- uflow_cnt  out  CNT_W  saturating count of underflow pixels.
- uflow_clr  in  1  synchronous clear of uflow_sticky and uflow_cnt.

## Operation
- **State:**
  - Two word slots, each with a valid bit.
  - Write pointer wp and read pointer rp, 1 bit each.
  - pix_idx, 0..PIX_PER_WORD-1.
  - occ, 0..2: valid slots plus in-flight reads.
  - rd_d: fifo_rd_en delayed by one cycle.
- **Fetch:**
  - At each edge, fifo_rd_en <= 1 when !fifo_empty, fifo_rd_en==0, and occ after this cycle's consume/drop is < 2. Otherwise fifo_rd_en <= 0.
  - Issuing a read increments occ. Back-to-back strobes never occur.
  - When rd_d==1, fifo_rdata is written into slot wp at that edge; that slot becomes valid and wp toggles.
- **Consume (de_in=1, slot rp valid):**
  - The pixel at index pix_idx is registered into pix_out.
  - MSB_FIRST=1 uses bits [WORD_W-1-pix_idx*PIX_W -: PIX_W]; MSB_FIRST=0 uses [pix_idx*PIX_W +: PIX_W].
  - When pix_idx==PIX_PER_WORD-1: slot invalidated, rp toggles, pix_idx <= 0, occ decrements. Otherwise pix_idx increments.
- **Underflow (de_in=1, slot rp invalid):**
  - pix_out <= UFLOW_RGB and pix_idx holds.
  - uflow_sticky <= 1; uflow_cnt increments, saturating at all-ones.
- **Blanking (de_in=0):** pix_out <= BLANK_RGB; no consumption.
- **Resync:**
  - Triggered by vs_in rising edge (vs_in & !vs_in_d), when RESYNC=1.
  - Evaluated after the same cycle's consume. If the resulting pix_idx != 0, the current slot is invalidated, rp toggles, occ decrements and pix_idx <= 0.
  - Full unconsumed words are kept.
  - With RESYNC=0 the edge is ignored.
- **uflow_clr:**
  - Clears sticky and count.
  - If an underflow pixel occurs in the same cycle, the event wins: sticky=1, count=1.
- A slot refilled by a landing read and a slot freed by consume in the same cycle are always different slots; both actions occur.

## Timing
- All outputs are registered.
- Reset values: fifo_rd_en=0, pix_out=0, de_out=0, hs_out=0, vs_out=0, uflow_sticky=0, uflow_cnt=0. Internal state: slots invalid, wp=rp=0, pix_idx=0, occ=0, rd_d=0.
- Latency: de_in/hs_in/vs_in to de_out/hs_out/vs_out is 1 cycle; pix_out is aligned with de_out.
- FIFO read latency is fixed at 1: data is sampled at the edge ending the cycle after fifo_rd_en.
- Startup with a non-empty FIFO, counting edges after rstn release:
  - Edge 1: fifo_rd_en=1.
  - Edge 2: rd_d=1.
  - Edge 3: slot 0 valid and second fifo_rd_en=1.
  - Edge 5: slot 1 valid.
- Sustained throughput is 1 word per PIX_PER_WORD cycles (≥2), so continuous de_in never underflows once both slots are filled, provided the FIFO is non-empty.
- Asserting rstn low mid-frame immediately forces all reset values. An in-flight FIFO read is discarded.

## Test plan
Benches use PIX_W=8 and PIX_PER_WORD=4 unless noted.

- **Reset:** hold rstn=0 with fifo_empty=0 and de_in=1 → all outputs 0 and fifo_rd_en stays 0. After release, the first fifo_rd_en arrives at edge 1.
- **Stream, MSB_FIRST=0:** FIFO holds 32'h03020100 then 32'h07060504; de_in high for 8 cycles after prefill → pix_out = 00,01,…,07 on consecutive cycles, each 1 cycle after de_in. fifo_rd_en never asserts twice in a row.
- **MSB_FIRST=1:** word 32'hA0B0C0D0 → pix_out A0,B0,C0,D0.
- **Underflow:** fifo_empty=1 always, de_in high 3 cycles → pix_out=UFLOW_RGB for 3 cycles, uflow_cnt=3, uflow_sticky=1. Pulse uflow_clr → both 0. With CNT_W=2, 5 events → uflow_cnt=3.
- **Resync:** consume 2 pixels of 32'h03020100, then vs_in rises with de_in=0; FIFO next holds 32'h07060504 → next de_in pixel is 04. Repeating with RESYNC=0 → next pixel is 02.
- **Blanking/sync:** de_in=0 with toggling hs_in/vs_in → pix_out=BLANK_RGB, and hs_out/vs_out equal hs_in/vs_in delayed exactly 1 cycle.
